// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit scheduler.
// Byte width, FSM state encoding, parameter defaults, one-hot helper.
package uart_pkg;

  localparam int BYTE_W = 8;

  localparam int DEF_N_REQ          = 4;
  localparam int DEF_GAP_CYCLES     = 2;
  localparam int DEF_TIMEOUT_CYCLES = 200000;

  localparam int WDOG_W = 24;
  localparam int GAP_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  function automatic logic [7:0] onehot8(
    input logic [2:0] idx
  );
    return 8'b1 << idx;
  endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports: req (requests), last_grant (previous winner) -> valid, winner.
module rr_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ
) (
  input  logic [N_REQ-1:0] req,
  input  logic [2:0]       last_grant,
  output logic             valid,
  output logic [2:0]       winner
);

  logic [7:0] req_pad;
  logic [3:0] idx4;
  logic [2:0] idx;

  // Walk from the farthest candidate back to the nearest so the
  // last hit (the first one after last_grant) wins.
  always_comb begin
    req_pad = 8'(req);
    valid   = 1'b0;
    winner  = last_grant;
    idx4    = '0;
    idx     = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      idx4 = {1'b0, last_grant} + 4'(i);
      if (idx4 >= 4'(N_REQ))
        idx4 = idx4 - 4'(N_REQ);
      idx = idx4[2:0];
      if (req_pad[idx]) begin
        valid  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one uart_tx among N_REQ requesters: round-robin grant,
// inter-byte gap and a watchdog on the frame.
// Ports: clk, rstn (async low); req/req_data in, ack/sent pulses out;
// tx_en/tx_data/tx_done to uart_tx; busy, cur_id, timeout_err status.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int N_REQ          = DEF_N_REQ,
  parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [N_REQ-1:0]        req,
  input  logic [BYTE_W*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]        ack,
  output logic [N_REQ-1:0]        sent,
  output logic                    tx_en,
  output logic [BYTE_W-1:0]       tx_data,
  input  logic                    tx_done,
  output logic                    busy,
  output logic [2:0]              cur_id,
  output logic                    timeout_err
);

  state_t              state, state_n;
  logic [2:0]          last_grant, last_n;
  logic [WDOG_W-1:0]   wdog, wdog_n;
  logic [GAP_W-1:0]    gap_cnt, gap_n;
  logic                tx_en_n, busy_n, to_n;
  logic [BYTE_W-1:0]   tx_data_n, sel_byte;
  logic [2:0]          cur_id_n;
  logic [N_REQ-1:0]    ack_n, sent_n;
  logic                arb_valid;
  logic [2:0]          winner;
  logic [7:0]          oh;

  rr_arbiter #(
    .N_REQ(N_REQ)
  ) u_arb (
    .req       (req),
    .last_grant(last_grant),
    .valid     (arb_valid),
    .winner    (winner)
  );

  always_comb begin
    sel_byte = '0;
    for (int i = 0; i < N_REQ; i++)
      if (3'(i) == winner)
        sel_byte = req_data[i*BYTE_W +: BYTE_W];
  end

  always_comb begin
    state_n   = state;
    tx_en_n   = tx_en;
    tx_data_n = tx_data;
    cur_id_n  = cur_id;
    last_n    = last_grant;
    wdog_n    = wdog;
    gap_n     = gap_cnt;
    ack_n     = '0;
    sent_n    = '0;
    to_n      = 1'b0;
    oh        = '0;
    unique case (state)
      ST_IDLE: begin
        if (arb_valid) begin
          oh        = onehot8(winner);
          state_n   = ST_SEND;
          tx_en_n   = 1'b1;
          tx_data_n = sel_byte;
          cur_id_n  = winner;
          last_n    = winner;
          ack_n     = oh[N_REQ-1:0];
          wdog_n    = '0;
        end
      end
      ST_SEND: begin
        // tx_done takes priority over a same-cycle watchdog expiry.
        if (tx_done) begin
          oh      = onehot8(cur_id);
          state_n = ST_GAP;
          tx_en_n = 1'b0;
          sent_n  = oh[N_REQ-1:0];
          wdog_n  = '0;
          gap_n   = '0;
        end else if (wdog == WDOG_W'(TIMEOUT_CYCLES - 1)) begin
          state_n = ST_GAP;
          tx_en_n = 1'b0;
          to_n    = 1'b1;
          wdog_n  = '0;
          gap_n   = '0;
        end else begin
          wdog_n = wdog + 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
          state_n = ST_IDLE;
          gap_n   = '0;
        end else begin
          gap_n = gap_cnt + 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
    busy_n = (state_n != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= ST_IDLE;
      tx_en       <= 1'b0;
      tx_data     <= '0;
      cur_id      <= '0;
      last_grant  <= 3'(N_REQ - 1);
      wdog        <= '0;
      gap_cnt     <= '0;
      ack         <= '0;
      sent        <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_n;
      tx_en       <= tx_en_n;
      tx_data     <= tx_data_n;
      cur_id      <= cur_id_n;
      last_grant  <= last_n;
      wdog        <= wdog_n;
      gap_cnt     <= gap_n;
      ack         <= ack_n;
      sent        <= sent_n;
      busy        <= busy_n;
      timeout_err <= to_n;
    end
  end

endmodule

// File: doc/uart_tx_scheduler.md
UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 SHALL have parameter N_REQ, default 4, meaning number of requesters sharing one uart_tx (legal 2..8).
REQ-002 SHALL have parameter GAP_CYCLES, default 2, meaning idle cycles with tx_en low between consecutive bytes (legal 1..255).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 200000, meaning the maximum cycles tx_en may stay high without tx_done (legal 16..2^24-1).
REQ-004 SHALL have port clk, input, 1, system clock; all logic rising-edge.
REQ-005 SHALL have port rstn, input, 1, reset, asynchronous, active-low.
REQ-006 SHALL have port req, input, N_REQ, per-requester "byte pending" level.
REQ-007 SHALL have port req_data, input, 8*N_REQ, byte of requester i on bits [8i+7:8i].
REQ-008 SHALL have port ack, output, N_REQ, one-cycle pulse: byte of requester i captured.
REQ-009 SHALL have port sent, output, N_REQ, one-cycle pulse: byte of requester i fully transmitted.
REQ-010 SHALL have port tx_en, output, 1, enable to uart_tx, held high for the whole frame.
REQ-011 SHALL have port tx_data, output, 8, byte to uart_tx, stable while tx_en high.
REQ-012 SHALL have port tx_done, input, 1, one-cycle completion pulse from uart_tx.
REQ-013 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-014 SHALL have port cur_id, output, 3, index of the requester currently owning uart_tx.
REQ-015 SHALL have port timeout_err, output, 1, one-cycle pulse on watchdog abort.

Function
REQ-016 SHALL implement states IDLE, SEND and GAP, all with registered outputs.
REQ-017 In IDLE with req nonzero at edge t, SHALL select the winner, capture its byte into tx_data, set cur_id, and enter SEND, so that tx_en=1 and ack[winner]=1 in cycle t+1.
REQ-018 Arbitration SHALL be round-robin: search starts at (last_grant+1) mod N_REQ and picks the first set req bit; last_grant updates only on grant.
REQ-019 req SHALL be ignored outside IDLE; a req still high after ack counts as a new byte and is sampled fresh at the next IDLE.
REQ-020 In SEND, tx_done=1 SHALL cause tx_en=0, sent[cur_id]=1 (one cycle), and a transition to GAP at the next edge.
REQ-021 GAP SHALL last exactly GAP_CYCLES cycles, then return to IDLE; minimum tx_done to next tx_en rise is GAP_CYCLES+1 cycles.
REQ-022 tx_done SHALL be ignored in IDLE and GAP.
REQ-023 A watchdog SHALL count cycles in SEND; on reaching TIMEOUT_CYCLES without tx_done, SHALL drop tx_en, pulse timeout_err, skip sent, and enter GAP.
REQ-024 tx_done arriving in the same cycle as timeout expiry SHALL count as success: sent pulses and timeout_err stays low.
REQ-025 tx_data and cur_id SHALL hold their last values outside SEND.
REQ-026 At most one ack bit and at most one sent bit SHALL be high in any cycle.

Reset
REQ-027 On rstn low, SHALL asynchronously force state=IDLE, tx_en=0, tx_data=0, ack=0, sent=0, busy=0, cur_id=0, timeout_err=0, watchdog=0, gap counter=0.
REQ-028 On reset, SHALL set last_grant=N_REQ-1 so that requester 0 has first priority after reset.
REQ-029 Reset asserted mid-frame SHALL abort it with no sent pulse; uart_tx is reset by the same rstn.

Structure
REQ-030 Shared package uart_pkg SHALL hold the byte width (8), the state encoding, and the default N_REQ, GAP_CYCLES and TIMEOUT_CYCLES values.
REQ-031 Round-robin selection SHALL be a sub-module rr_arbiter (inputs req and last_grant; outputs valid and winner index), combinational, instantiated once.
REQ-032 The top level SHALL contain the FSM, data capture, gap counter and watchdog; it SHALL NOT instantiate uart_tx (the integrator wires it).

Verification
REQ-033 Single request: req=4'b0001, req_data[7:0]=8'hA5 -> ack[0] pulses one cycle later, tx_en=1 and tx_data=8'hA5 until tx_done, then sent[0] pulses.
REQ-034 Fairness: req=4'b1111 held for 8 bytes after reset -> grant order 0,1,2,3,0,1,2,3, with exactly GAP_CYCLES+1 cycles from each tx_done to the next tx_en rise.
REQ-035 Skip: req=4'b1010 with last_grant=1 -> grant 3 then 1; requesters 0 and 2 never acked.
REQ-036 Timeout: grant requester 2 and withhold tx_done -> after TIMEOUT_CYCLES, tx_en=0 and timeout_err pulses, no sent[2]; next grant proceeds normally.
REQ-037 Boundary: tx_done coincident with timeout expiry -> sent pulses, no timeout_err; tx_done in IDLE -> no state change.
REQ-038 Reset: rstn low mid-frame -> all outputs 0 immediately; after release with req=4'b1001 -> requester 0 granted first.
